// File: rtl/serial_paralelo_phy_rx_sync_if.sv
// Purpose: bundles the serial input and parallel-side outputs of the rx sync block.
// Ports:   data_in (serial bit, MSB first), data_out (payload word), valid_out (strobe),
//          active (link locked). master = line/consumer side, slave = receiver.
interface serial_paralelo_phy_rx_sync_if #(
  parameter int WIDTH = 8
);
  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
  );
endinterface

// File: rtl/serial_paralelo_phy_rx_sync.sv
// Purpose: serial-to-parallel receiver that hunts bit-by-bit for COM and locks after
//          LOCK_COUNT aligned COM words; presents only non-COM payload words.
// Latency: data_out/valid_out update on the edge sampling a word's last bit (0 cycles).
// Backpressure: none; the serial line cannot be stalled, valid_out is a 1-cycle strobe.
// Ports:   clk_32f (bit clock), reset_L (async active-low), rx (slave modport: data_in,
//          data_out, valid_out, active).
module serial_paralelo_phy_rx_sync #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COM        = 8'hBC,
  parameter int               LOCK_COUNT = 4
) (
  input  logic                          clk_32f,
  input  logic                          reset_L,
  serial_paralelo_phy_rx_sync_if.slave  rx
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CCNT_LAST = CW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [CW-1:0]    ccnt_q, ccnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             active_q, active_d;

  logic [WIDTH-1:0] word;
  logic             boundary;
  logic             is_com;

  always_comb begin
    // The current bit completes the candidate word on this very edge.
    word     = {sr_q, rx.data_in};
    boundary = (bcnt_q == BCNT_LAST);
    is_com   = (word == COM);

    state_d  = state_q;
    sr_d     = word[WIDTH-2:0];
    bcnt_d   = boundary ? '0 : bcnt_q + BW'(1);
    ccnt_d   = ccnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;

    case (state_q)
      SEARCH: begin
        // Any bit position may be a boundary; a hit re-phases the bit counter so
        // the next boundary falls exactly WIDTH bits later.
        if (is_com) begin
          bcnt_d  = '0;
          ccnt_d  = CW'(1);
          state_d = (LOCK_COUNT == 1) ? ACTIVE : LOCKING;
        end
      end
      LOCKING: begin
        if (boundary) begin
          if (is_com) begin
            ccnt_d = ccnt_q + CW'(1);
            if (ccnt_d == CCNT_LAST) begin
              state_d = ACTIVE;
            end
          end else begin
            // Candidate was a false comma; resume hunting from the next bit.
            ccnt_d  = '0;
            state_d = SEARCH;
          end
        end
      end
      ACTIVE: begin
        // COM words are fill; only payload words are forwarded.
        if (boundary && !is_com) begin
          data_d  = word;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase

    active_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= SEARCH;
      sr_q     <= '0;
      bcnt_q   <= '0;
      ccnt_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bcnt_q   <= bcnt_d;
      ccnt_q   <= ccnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
    end
  end

  assign rx.data_out  = data_q;
  assign rx.valid_out = valid_q;
  assign rx.active    = active_q;

endmodule

// File: tb/tb_serial_paralelo_phy_rx_sync.sv
// Purpose: directed bench for serial_paralelo_phy_rx_sync with a bit-history model.
// Latency: outputs checked every falling edge against the model; literal pins after.
// Backpressure: n/a.
module tb_serial_paralelo_phy_rx_sync;

  localparam int         W     = 8;
  localparam logic [7:0] COM_V = 8'hBC;
  localparam int         N     = 4;

  logic clk_32f = 1'b0;
  logic reset_L = 1'b0;

  serial_paralelo_phy_rx_sync_if #(.WIDTH(W)) bus ();

  serial_paralelo_phy_rx_sync #(
    .WIDTH      (W),
    .COM        (COM_V),
    .LOCK_COUNT (N)
  ) dut (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .rx      (bus)
  );

  always #5 clk_32f = ~clk_32f;

  int tests = 0;
  int fails = 0;

  // Model state: full bit history since reset, plus the index of the bit that
  // completed the accepted comma (all later boundaries are multiples of W away).
  bit         hist[$];
  int         m_mode;    // 0 hunting, 1 confirming, 2 locked
  int         m_anchor;
  int         m_cnt;
  int         bit_idx;
  logic [7:0] exp_data;
  logic       exp_valid;
  logic       exp_active;
  logic       chk_en = 1'b0;

  // Observations of the DUT, compared afterwards with hand-computed constants.
  int         rise_idx;
  bit         seen;
  int         v_idx[$];
  logic [7:0] v_dat[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_word();
    logic [7:0] w;
    w = '0;
    for (int k = 0; k < W; k++) begin
      int idx;
      idx = hist.size() - W + k;
      if (idx >= 0) w[W-1-k] = hist[idx];
    end
    return w;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_mode     = 0;
    m_anchor   = 0;
    m_cnt      = 0;
    bit_idx    = 0;
    exp_data   = '0;
    exp_valid  = 1'b0;
    exp_active = 1'b0;
    rise_idx   = -1;
    seen       = 1'b0;
    v_idx.delete();
    v_dat.delete();
  endtask

  task automatic model_step(input bit b);
    logic [7:0] w;
    bit         at_bound;
    hist.push_back(b);
    w         = model_word();
    at_bound  = (bit_idx > m_anchor) && (((bit_idx - m_anchor) % W) == 0);
    exp_valid = 1'b0;
    if (m_mode == 0) begin
      if (w == COM_V) begin
        m_anchor = bit_idx;
        m_cnt    = 1;
        m_mode   = (N == 1) ? 2 : 1;
      end
    end else if (m_mode == 1) begin
      if (at_bound) begin
        if (w == COM_V) begin
          m_cnt++;
          if (m_cnt == N) m_mode = 2;
        end else begin
          m_mode = 0;
        end
      end
    end else begin
      if (at_bound && w != COM_V) begin
        exp_data  = w;
        exp_valid = 1'b1;
      end
    end
    exp_active = (m_mode == 2);
  endtask

  always @(negedge clk_32f) begin
    if (chk_en) begin
      check("data_out",  {24'd0, bus.data_out}, {24'd0, exp_data});
      check("valid_out", {31'd0, bus.valid_out}, {31'd0, exp_valid});
      check("active",    {31'd0, bus.active},    {31'd0, exp_active});
    end
  end

  task automatic send_bit(input bit b);
    @(negedge clk_32f);
    bus.data_in = b;
    @(posedge clk_32f);
    #1;
    model_step(b);
    if (bus.active === 1'b1 && !seen) begin
      seen     = 1'b1;
      rise_idx = bit_idx;
    end
    if (bus.valid_out === 1'b1) begin
      v_idx.push_back(bit_idx);
      v_dat.push_back(bus.data_out);
    end
    bit_idx++;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int k = W - 1; k >= 0; k--) send_bit(w[k]);
  endtask

  task automatic apply_reset();
    reset_L = 1'b0;
    #1;
    model_reset();
    repeat (3) begin
      @(negedge clk_32f);
      bus.data_in = ~bus.data_in;
      @(posedge clk_32f);
    end
    #2;
    reset_L = 1'b1;
  endtask

  task automatic check_pulse(input string name, input int n, input int idx, input logic [7:0] dat);
    if (n >= v_idx.size()) begin
      tests++;
      fails++;
      $display("FAIL %s: only %0d pulses, expected pulse #%0d", name, v_idx.size(), n);
    end else begin
      check({name, "_idx"}, v_idx[n], idx);
      check({name, "_dat"}, {24'd0, v_dat[n]}, {24'd0, dat});
    end
  endtask

  initial begin
    bus.data_in = 1'b0;
    model_reset();
    #2;
    // Asynchronous reset: outputs must be clear before any clock edge.
    check("rst_async_data",   {24'd0, bus.data_out}, 32'd0);
    check("rst_async_valid",  {31'd0, bus.valid_out}, 32'd0);
    check("rst_async_active", {31'd0, bus.active},    32'd0);
    chk_en = 1'b1;

    // Reset held with toggling input, then basic lock and payload.
    apply_reset();
    check("rst_hold_data",   {24'd0, bus.data_out}, 32'd0);
    check("rst_hold_active", {31'd0, bus.active},   32'd0);
    for (int i = 0; i < 4; i++) send_word(COM_V);
    send_word(8'hA5);
    send_word(8'h3C);
    check("basic_rise", rise_idx, 31);
    check("basic_npulse", v_idx.size(), 2);
    check_pulse("basic_p0", 0, 39, 8'hA5);
    check_pulse("basic_p1", 1, 47, 8'h3C);

    // Misaligned start: three stray bits shift every boundary by 3.
    apply_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_word(COM_V);
    send_word(8'h5A);
    check("misal_rise", rise_idx, 34);
    check_pulse("misal_p0", 0, 42, 8'h5A);

    // Broken lock, then COM inside payload.
    apply_reset();
    send_word(COM_V); send_word(COM_V); send_word(8'h55);
    check("broken_noact", {31'd0, bus.active}, 32'd0);
    for (int i = 0; i < 4; i++) send_word(COM_V);
    send_word(8'h11);
    check("broken_rise", rise_idx, 55);
    check_pulse("broken_p0", 0, 63, 8'h11);
    send_word(8'hA5);
    send_word(COM_V);
    check("compay_hold", {24'd0, bus.data_out}, {24'd0, 8'hA5});
    send_word(8'hC3);
    check("compay_npulse", v_idx.size(), 3);
    check_pulse("compay_p1", 1, 71, 8'hA5);
    check_pulse("compay_p2", 2, 87, 8'hC3);

    // Mismatch on the final lock word: never goes active, relocks afterwards.
    apply_reset();
    for (int i = 0; i < 3; i++) send_word(COM_V);
    send_word(8'h55);
    check("lastlock_noact", {31'd0, seen}, 32'd0);
    for (int i = 0; i < 4; i++) send_word(COM_V);
    check("lastlock_rise", rise_idx, 63);

    // Reset mid-word while active and holding a payload.
    send_word(8'h5A);
    check_pulse("midrst_pre", 0, 71, 8'h5A);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #2;
    reset_L = 1'b0;
    #1;
    check("midrst_data",   {24'd0, bus.data_out}, 32'd0);
    check("midrst_valid",  {31'd0, bus.valid_out}, 32'd0);
    check("midrst_active", {31'd0, bus.active},    32'd0);
    model_reset();
    repeat (2) @(posedge clk_32f);
    #2;
    reset_L = 1'b1;
    for (int i = 0; i < 4; i++) send_word(COM_V);
    check("midrst_rise", rise_idx, 31);
    send_bit(1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
